baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 126 ++++++++++++
 tb/tb_baud_gen_frac.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: integer divisor plus a phase accumulator that
// stretches a period by one cycle on each carry, with mid-bit and bit-boundary ticks.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 325,
    parameter int DEFAULT_FRAC = 133
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_resync,
    input  logic              i_div_load,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_baud_tick,
    output logic              o_mid_tick,
    output logic              o_bit_tick,
    output logic              o_div_ack,
    output logic              o_div_err
);

    localparam int SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int CNT_W = DIV_W + 1;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    logic [DIV_W-1:0]  r_curInt;
    logic [FRAC_W-1:0] r_curFrac;
    logic [DIV_W-1:0]  r_pendInt;
    logic [FRAC_W-1:0] r_pendFrac;
    logic              r_pending;
    logic [CNT_W-1:0]  r_count;
    logic [FRAC_W-1:0] r_acc;
    logic              r_extend;
    logic [SUB_W-1:0]  r_sub;

    logic              w_loadOk;
    logic              w_applyAny;
    logic [DIV_W-1:0]  w_newInt;
    logic [FRAC_W-1:0] w_newFrac;
    logic [CNT_W-1:0]  w_period;
    logic              w_periodEnd;
    logic [FRAC_W:0]   w_accSum;
    logic [SUB_W-1:0]  w_subNext;

    // A load arriving on the apply edge bypasses the pending register.
    assign w_loadOk    = i_div_load && (i_div_int >= MIN_DIV);
    assign w_applyAny  = w_loadOk || r_pending;
    assign w_newInt    = w_loadOk ? i_div_int  : r_pendInt;
    assign w_newFrac   = w_loadOk ? i_div_frac : r_pendFrac;
    assign w_period    = {1'b0, r_curInt} + CNT_W'(r_extend);
    assign w_periodEnd = (r_count == w_period - CNT_W'(1));
    assign w_accSum    = {1'b0, r_acc} + {1'b0, r_curFrac};
    assign w_subNext   = r_sub + SUB_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_curInt    <= DIV_W'(DEFAULT_INT);
            r_curFrac   <= FRAC_W'(DEFAULT_FRAC);
            r_pendInt   <= '0;
            r_pendFrac  <= '0;
            r_pending   <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_extend    <= 1'b0;
            r_sub       <= '0;
            o_baud_tick <= 1'b0;
            o_mid_tick  <= 1'b0;
            o_bit_tick  <= 1'b0;
            o_div_ack   <= 1'b0;
            o_div_err   <= 1'b0;
        end else begin
            o_baud_tick <= 1'b0;
            o_mid_tick  <= 1'b0;
            o_bit_tick  <= 1'b0;
            o_div_ack   <= 1'b0;
            o_div_err   <= i_div_load && !w_loadOk;

            if (w_loadOk) begin
                r_pendInt  <= i_div_int;
                r_pendFrac <= i_div_frac;
                r_pending  <= 1'b1;
            end

            if (i_resync) begin
                r_count  <= '0;
                r_acc    <= '0;
                r_extend <= 1'b0;
                r_sub    <= '0;
            end else if (!i_valid) begin
                r_count  <= '0;
                r_acc    <= '0;
                r_extend <= 1'b0;
                r_sub    <= '0;
                if (w_applyAny) begin
                    r_curInt  <= w_newInt;
                    r_curFrac <= w_newFrac;
                    r_pending <= 1'b0;
                    o_div_ack <= 1'b1;
                end
            end else if (w_periodEnd) begin
                r_count     <= '0;
                r_sub       <= w_subNext;
                o_baud_tick <= 1'b1;
                o_mid_tick  <= (w_subNext == SUB_W'(OVERSAMPLE / 2));
                o_bit_tick  <= (w_subNext == '0);
                // A divisor change restarts the fractional phase from zero.
                if (w_applyAny) begin
                    r_curInt  <= w_newInt;
                    r_curFrac <= w_newFrac;
                    r_pending <= 1'b0;
                    r_acc     <= '0;
                    r_extend  <= 1'b0;
                    o_div_ack <= 1'b1;
                end else begin
                    r_acc    <= w_accSum[FRAC_W-1:0];
                    r_extend <= w_accSum[FRAC_W];
                end
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: tick times come from the closed form
// T(n) = n*int + floor((n-1)*frac / 2^FRAC_W) measured from the start of a run.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 8;
    localparam int OS     = 16;

    localparam logic [4:0] F_BAUD = 5'd1;
    localparam logic [4:0] F_MID  = 5'd2;
    localparam logic [4:0] F_BIT  = 5'd4;
    localparam logic [4:0] F_ACK  = 5'd8;
    localparam logic [4:0] F_ERR  = 5'd16;

    typedef struct {
        int         cyc;
        logic [4:0] flags;
    } exp_t;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_valid;
    logic              i_resync;
    logic              i_div_load;
    logic [DIV_W-1:0]  i_div_int;
    logic [FRAC_W-1:0] i_div_frac;
    logic              o_baud_tick;
    logic              o_mid_tick;
    logic              o_bit_tick;
    logic              o_div_ack;
    logic              o_div_err;

    exp_t       expQ[$];
    logic [4:0] expMap[int];
    int         testsRun = 0;
    int         testsFailed = 0;
    int         edgeNum = 0;

    always #5 clk = ~clk;

    baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
        .DEFAULT_INT(325), .DEFAULT_FRAC(133)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_resync(i_resync),
        .i_div_load(i_div_load), .i_div_int(i_div_int), .i_div_frac(i_div_frac),
        .o_baud_tick(o_baud_tick), .o_mid_tick(o_mid_tick), .o_bit_tick(o_bit_tick),
        .o_div_ack(o_div_ack), .o_div_err(o_div_err)
    );

    always @(posedge clk) edgeNum <= edgeNum + 1;

    function automatic int tickOff(int n, int dInt, int dFrac);
        return n * dInt + (((n - 1) * dFrac) >> FRAC_W);
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNum);
        end
    endtask

    task automatic applyStimulus(logic valid, logic resync, logic load, int dInt, int dFrac);
        i_valid    = valid;
        i_resync   = resync;
        i_div_load = load;
        i_div_int  = DIV_W'(dInt);
        i_div_frac = FRAC_W'(dFrac);
        @(posedge clk);
        #1;
    endtask

    task automatic addExp(int cyc, logic [4:0] f);
        if (expMap.exists(cyc)) expMap[cyc] = expMap[cyc] | f;
        else expMap[cyc] = f;
    endtask

    // subCount is the number of ticks since the sub-tick counter last restarted.
    task automatic addTick(int t, int subCount);
        logic [4:0] f;
        int s;
        s = subCount % OS;
        f = F_BAUD;
        if (s == OS / 2) f = f | F_MID;
        if (s == 0) f = f | F_BIT;
        addExp(t, f);
    endtask

    task automatic commitExp();
        foreach (expMap[k]) expQ.push_back('{k, expMap[k]});
        expMap.delete();
    endtask

    task automatic checkAllZero(string name);
        checkOutput({name, " baud"}, int'(o_baud_tick), 0);
        checkOutput({name, " mid"},  int'(o_mid_tick), 0);
        checkOutput({name, " bit"},  int'(o_bit_tick), 0);
        checkOutput({name, " ack"},  int'(o_div_ack), 0);
        checkOutput({name, " err"},  int'(o_div_err), 0);
    endtask

    task automatic finishRun();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("leftover expected events", expQ.size(), 0);
        expQ.delete();
    endtask

    // Every run starts with a load while disabled (ack at the next edge), then enables.
    task automatic runBasic(int dInt, int dFrac, int n, bit doBad);
        int base, lastT, badAt, badVal;
        base = edgeNum + 1;
        addExp(base, F_ACK);
        for (int k = 1; k <= n; k++) addTick(base + tickOff(k, dInt, dFrac), k);
        lastT = base + tickOff(n, dInt, dFrac);
        badAt = -1;
        badVal = int'($urandom % 2);
        if (doBad) begin
            badAt = base + 1 + int'($urandom % 32'(lastT - base));
            addExp(badAt, F_ERR);
        end
        commitExp();
        applyStimulus(0, 0, 1, dInt, dFrac);
        while (edgeNum < lastT) begin
            if (edgeNum + 1 == badAt) applyStimulus(1, 0, 1, badVal, int'($urandom % 256));
            else applyStimulus(1, 0, 0, 0, 0);
        end
        finishRun();
    endtask

    task automatic runMidLoad(int dInt, int dFrac, int newInt, int newFrac, int loadOff, int n);
        int base, t1, lastT;
        base = edgeNum + 1;
        addExp(base, F_ACK);
        t1 = base + dInt;
        addTick(t1, 1);
        addExp(t1, F_ACK);
        for (int m = 1; m <= n; m++) addTick(t1 + tickOff(m, newInt, newFrac), 1 + m);
        lastT = t1 + tickOff(n, newInt, newFrac);
        commitExp();
        applyStimulus(0, 0, 1, dInt, dFrac);
        while (edgeNum < lastT) begin
            if (edgeNum + 1 == base + loadOff) applyStimulus(1, 0, 1, newInt, newFrac);
            else applyStimulus(1, 0, 0, 0, 0);
        end
        finishRun();
    endtask

    task automatic runResync(int dInt, int dFrac, int rOff, int n);
        int base, r, lastT;
        base = edgeNum + 1;
        r = base + rOff;
        addExp(base, F_ACK);
        for (int k = 1; base + tickOff(k, dInt, dFrac) < r; k++) addTick(base + tickOff(k, dInt, dFrac), k);
        for (int m = 1; m <= n; m++) addTick(r + tickOff(m, dInt, dFrac), m);
        lastT = r + tickOff(n, dInt, dFrac);
        commitExp();
        applyStimulus(0, 0, 1, dInt, dFrac);
        while (edgeNum < lastT) applyStimulus(1, edgeNum + 1 == r, 0, 0, 0);
        finishRun();
    endtask

    // Reset lands in the second period with a load pending; afterwards the defaults run.
    task automatic runReset(int dInt, int dFrac);
        int base, loadAt, rs, base2, lastT, e, newInt;
        base = edgeNum + 1;
        loadAt = base + dInt + 1;
        rs = base + dInt + 2 + int'($urandom % 32'(dInt - 2));
        newInt = 2 + int'($urandom % 19);
        addExp(base, F_ACK);
        addTick(base + dInt, 1);
        base2 = rs + 3;
        for (int k = 1; k <= 3; k++) addTick(base2 + tickOff(k, 325, 133), k);
        lastT = base2 + tickOff(3, 325, 133);
        commitExp();
        applyStimulus(0, 0, 1, dInt, dFrac);
        while (edgeNum < lastT) begin
            e = edgeNum + 1;
            i_reset = (e >= rs && e <= rs + 2);
            applyStimulus(e != rs + 3, 0, e == loadAt, newInt, 0);
            if (edgeNum >= rs && edgeNum <= rs + 2) checkAllZero("in-reset");
        end
        i_reset = 1'b0;
        finishRun();
    endtask

    // Every output pulse is matched, in order, against the next expected event.
    always @(negedge clk) begin
        logic [4:0] f;
        exp_t e;
        f = {o_div_err, o_div_ack, o_bit_tick, o_mid_tick, o_baud_tick};
        if (f != 5'd0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected output flags", int'(f), 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("event edge", edgeNum, e.cyc);
                checkOutput("event flags", int'(f), int'(e.flags));
            end
        end
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind, dInt, dFrac, n;
        i_reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkAllZero("reset");
        i_reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        runBasic(4, 0, 20, 0);
        runBasic(4, 128, 10, 0);
        runMidLoad(10, 0, 6, 0, 3, 8);
        runBasic(7, 37, 6, 1);
        runResync(8, 0, 5, 6);
        runReset(6, 0);

        for (int it = 0; it < 12; it++) begin
            kind  = int'($urandom % 4);
            dInt  = 2 + int'($urandom % 19);
            dFrac = int'($urandom % 256);
            n     = 1 + int'($urandom % 24);
            case (kind)
                0: runBasic(dInt, dFrac, n, bit'($urandom % 2));
                1: runMidLoad(dInt, dFrac, 2 + int'($urandom % 19), int'($urandom % 256),
                              1 + int'($urandom % 32'(dInt)), n);
                2: runResync(dInt, dFrac, 1 + int'($urandom % 32'(3 * dInt)), n);
                default: runReset(4 + int'($urandom % 9), dFrac);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
